unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port, fixed-latency instruction/data memory between the pipeline's fetch port (IF) and its load/store port (MEM).
- Serialises accesses and returns read data to the correct requester.
- Generates the stall signals the hazard logic uses to freeze PC, IF/ID and downstream stages.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Sits between the pipeline datapath and the memory macro.

Parameters:
- ADDR_W, 9: byte address width of both ports and memory.
- DATA_W, 32: data width.
- MEM_LAT, 2: cycles from mem_en to valid mem_rdata. Must be ≥1.
- STARVE_MAX, 4: consecutive DM grants with if_req pending before IF is forced.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  PC redirect; discards the in-flight fetch result
- if_valid  out  1  one-cycle fetch completion
- if_rdata  out  DATA_W  fetch data, valid when if_valid=1
- if_stall  out  1  if_req & ~if_valid
- dm_req  in  1  data request; level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_valid  out  1  one-cycle data completion
- dm_rdata  out  DATA_W  load data, valid when dm_valid=1 and the access is a read
- dm_stall  out  1  dm_req & ~dm_valid
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset: every output is 0 (if_stall/dm_stall still follow their equations). FSM goes to ARB_IDLE, latency counter and starve counter go to 0. An in-flight access is dropped and no valid is produced for it.
- FSM states: ARB_IDLE, ARB_IF, ARB_DM_RD, ARB_DM_WR.
- ARB_IDLE arbitration, evaluated each cycle:
  - dm_req wins if starve count < STARVE_MAX or if_req=0.
  - Otherwise if_req wins.
  - No request: stay in ARB_IDLE.
- Issue: the grant is registered. In the cycle T after the decision, mem_en=1 and mem_we/addr/wdata/be carry the granted request's values. mem_be is all-ones for reads. mem_en is 0 in every other cycle.
- Reads (ARB_IF, ARB_DM_RD):
  - The counter loads MEM_LAT at T and decrements.
  - In cycle T+MEM_LAT, the owner's valid pulses and rdata is passed combinationally from mem_rdata.
  - The next state is ARB_IDLE; the earliest next mem_en is T+MEM_LAT+2.
  - Request-to-valid latency from idle is 1+MEM_LAT cycles.
- Writes (ARB_DM_WR): dm_valid pulses in cycle T+1, then the FSM returns to ARB_IDLE.
- Requester contract: req is sampled high during its valid cycle (the arbiter ignores it there). A req still high in the cycle after valid is a new request.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each DM grant made while if_req=1.
  - Clears on each IF grant.
  - Holds otherwise.
- if_kill:
  - If asserted in any cycle while the FSM is in ARB_IF, the pending if_valid is suppressed.
  - The FSM still waits the full latency; memory reads cannot be cancelled.
  - if_kill in ARB_IDLE or a DM state has no effect.
  - A new fetch requested under a kill is granted only after the current access finishes.
- Simultaneous if_req and dm_req in ARB_IDLE follow the arbitration rule above; the loser's stall stays asserted.
- Outputs for the non-owning port: valid=0, rdata=0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_IF, ARB_DM_RD, ARB_DM_WR};
  - typedef struct mem_req_t {we, addr, wdata, be};
  - localparam LAT_W = $clog2(MEM_LAT+1).
- One natural sub-module: arb_starve_ctr, a saturating counter with inc, clr and at_max outputs.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Fetch alone:
  - Stimulus: if_req=1, if_addr=0x010 at cycle 0; mem returns 0x00500093.
  - Required: mem_en=1, addr 0x010 in cycle 1. if_valid=1 with if_rdata=0x00500093 in cycle 3. if_stall=1 in cycles 0–2.
- Collision:
  - Stimulus: if_req and dm_req (load, 0x040) both high at cycle 0.
  - Required: DM issues in cycle 1 and dm_valid pulses in cycle 3. IF issues in cycle 5.
- Store:
  - Stimulus: dm_req, dm_we=1, addr 0x044, wdata 0xDEADBEEF, be 4'b0011.
  - Required: mem_we=1 with those values in cycle 1, dm_valid in cycle 2.
- Starvation:
  - Stimulus: dm_req held continuously (new requests) and if_req held.
  - Required: after 4 DM grants the 5th grant goes to IF; the counter then clears and DM resumes.
- Kill:
  - Stimulus: fetch issued in cycle 1, if_kill=1 in cycle 2.
  - Required: no if_valid in cycle 3. A following request is granted at the normal slot (cycle 4), with mem_en in cycle 5.
- Reset mid-read:
  - Stimulus: reset in cycle 2 of a DM read.
  - Required: no dm_valid, all outputs 0 in cycle 3, and a new request issues normally afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned LAT_W      = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF    = 2'd1,
        ARB_DM_RD = 2'd2,
        ARB_DM_WR = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// Saturating count of data grants made while a fetch was waiting.
module arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] count;

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch and load/store.
module unified_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [BE_W-1:0]   dm_be,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              grant_if;
    logic              grant_dm;
    logic              starve_at_max;
    logic [LAT_W-1:0]  lat_cnt;
    logic              killed;
    logic              done;
    mem_req_t          req_sel;

    assign done = (lat_cnt == '0);

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_dm & if_req),
        .clr    (grant_if),
        .at_max (starve_at_max)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration in idle; every access state returns to idle once its count expires.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dm_req && (!starve_at_max || !if_req)) begin
                    grant_dm   = 1'b1;
                    state_next = dm_we ? ARB_DM_WR : ARB_DM_RD;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = ARB_IF;
                end
            end
            ARB_IF, ARB_DM_RD, ARB_DM_WR: begin
                if (done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Payload of the winning request; reads drive all byte enables.
    always_comb begin
        req_sel = '0;
        if (grant_dm) begin
            req_sel.we    = dm_we;
            req_sel.addr  = dm_addr;
            req_sel.wdata = dm_we ? dm_wdata : '0;
            req_sel.be    = dm_we ? dm_be : '1;
        end else if (grant_if) begin
            req_sel.addr  = if_addr;
            req_sel.be    = '1;
        end
    end

    // Registered memory strobe, latency counter and fetch-kill flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            lat_cnt   <= '0;
            killed    <= 1'b0;
        end else begin
            mem_en    <= grant_if | grant_dm;
            mem_we    <= req_sel.we;
            mem_addr  <= req_sel.addr;
            mem_wdata <= req_sel.wdata;
            mem_be    <= req_sel.be;
            if (grant_dm && dm_we) begin
                lat_cnt <= LAT_W'(1);
            end else if (grant_if || grant_dm) begin
                lat_cnt <= LAT_W'(MEM_LAT);
            end else if (!done) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (grant_if) begin
                killed <= 1'b0;
            end else if ((state == ARB_IF) && if_kill) begin
                killed <= 1'b1;
            end
        end
    end

    // Completion pulses and read-data steering to the owning port.
    always_comb begin
        if_valid = 1'b0;
        if_rdata = '0;
        dm_valid = 1'b0;
        dm_rdata = '0;
        if (!reset && done) begin
            case (state)
                ARB_IF: begin
                    if (!killed && !if_kill) begin
                        if_valid = 1'b1;
                        if_rdata = mem_rdata;
                    end
                end
                ARB_DM_RD: begin
                    dm_valid = 1'b1;
                    dm_rdata = mem_rdata;
                end
                ARB_DM_WR: dm_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with MEM_LAT=2, STARVE_MAX=4.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    unified_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller #1 after a posedge with reset low: that cycle is cycle 0.
    task automatic do_reset();
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_kill   = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_be     = '0;
        mem_rdata = 32'hA5A5_5A5A;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_mem_en",   32'(mem_en),   32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_dm_valid", 32'(dm_valid), 32'd0);
        check("rst_mem_be",   32'(mem_be),   32'd0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fetch alone
        do_reset();
        if_req = 1'b1; if_addr = 9'h010; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        check("f_stall_c0", 32'(if_stall), 32'd1);
        check("f_en_c0",    32'(mem_en),   32'd0);
        next_cycle(); @(negedge clk);
        check("f_en_c1",    32'(mem_en),   32'd1);
        check("f_addr_c1",  32'(mem_addr), 32'h010);
        check("f_we_c1",    32'(mem_we),   32'd0);
        check("f_be_c1",    32'(mem_be),   32'hF);
        check("f_stall_c1", 32'(if_stall), 32'd1);
        next_cycle(); @(negedge clk);
        check("f_en_c2",    32'(mem_en),   32'd0);
        check("f_val_c2",   32'(if_valid), 32'd0);
        check("f_stall_c2", 32'(if_stall), 32'd1);
        next_cycle(); @(negedge clk);
        check("f_val_c3",   32'(if_valid), 32'd1);
        check("f_data_c3",  if_rdata,      32'h0050_0093);
        check("f_stall_c3", 32'(if_stall), 32'd0);
        check("f_dmval_c3", 32'(dm_valid), 32'd0);
        check("f_dmdat_c3", dm_rdata,      32'd0);
        next_cycle(); if_req = 1'b0; @(negedge clk);
        check("f_val_c4",   32'(if_valid), 32'd0);
        check("f_data_c4",  if_rdata,      32'd0);

        // Collision: data wins, fetch follows
        do_reset();
        if_req = 1'b1; if_addr = 9'h010;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h040; mem_rdata = 32'h1111_2222;
        next_cycle(); @(negedge clk);
        check("c_en_c1",    32'(mem_en),   32'd1);
        check("c_addr_c1",  32'(mem_addr), 32'h040);
        check("c_istall_c1",32'(if_stall), 32'd1);
        check("c_dstall_c1",32'(dm_stall), 32'd1);
        next_cycle(); next_cycle(); @(negedge clk);
        check("c_dval_c3",  32'(dm_valid), 32'd1);
        check("c_ddat_c3",  dm_rdata,      32'h1111_2222);
        check("c_ival_c3",  32'(if_valid), 32'd0);
        check("c_idat_c3",  if_rdata,      32'd0);
        next_cycle(); dm_req = 1'b0; @(negedge clk);
        check("c_en_c4",    32'(mem_en),   32'd0);
        next_cycle(); @(negedge clk);
        check("c_en_c5",    32'(mem_en),   32'd1);
        check("c_addr_c5",  32'(mem_addr), 32'h010);
        next_cycle(); next_cycle(); @(negedge clk);
        check("c_ival_c7",  32'(if_valid), 32'd1);
        next_cycle(); if_req = 1'b0;

        // Store
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h044; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        next_cycle(); @(negedge clk);
        check("s_en_c1",    32'(mem_en),    32'd1);
        check("s_we_c1",    32'(mem_we),    32'd1);
        check("s_addr_c1",  32'(mem_addr),  32'h044);
        check("s_wd_c1",    mem_wdata,      32'hDEAD_BEEF);
        check("s_be_c1",    32'(mem_be),    32'h3);
        check("s_val_c1",   32'(dm_valid),  32'd0);
        next_cycle(); @(negedge clk);
        check("s_val_c2",   32'(dm_valid),  32'd1);
        check("s_stall_c2", 32'(dm_stall),  32'd0);
        check("s_en_c2",    32'(mem_en),    32'd0);
        next_cycle(); dm_req = 1'b0; dm_we = 1'b0; @(negedge clk);
        check("s_val_c3",   32'(dm_valid),  32'd0);

        // Starvation: four data grants, then fetch, then data again
        do_reset();
        if_req = 1'b1; if_addr = 9'h100;
        dm_req = 1'b1; dm_addr = 9'h080; mem_rdata = 32'h0000_00AA;
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            if ((c % 4) == 1) begin
                check($sformatf("sv_en_c%0d", c),   32'(mem_en),   32'd1);
                check($sformatf("sv_addr_c%0d", c), 32'(mem_addr), (c == 17) ? 32'h100 : 32'h080);
            end
            if (c == 19) begin
                check("sv_ival_c19", 32'(if_valid), 32'd1);
            end
            next_cycle();
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Kill: in-flight fetch dropped, redirected fetch issues at normal slot
        do_reset();
        if_req = 1'b1; if_addr = 9'h020; mem_rdata = 32'h0000_1234;
        next_cycle(); @(negedge clk);
        check("k_en_c1",    32'(mem_en),   32'd1);
        check("k_addr_c1",  32'(mem_addr), 32'h020);
        next_cycle(); if_kill = 1'b1; if_addr = 9'h030;
        next_cycle(); if_kill = 1'b0; @(negedge clk);
        check("k_val_c3",   32'(if_valid), 32'd0);
        check("k_data_c3",  if_rdata,      32'd0);
        check("k_stall_c3", 32'(if_stall), 32'd1);
        next_cycle(); @(negedge clk);
        check("k_en_c4",    32'(mem_en),   32'd0);
        next_cycle(); @(negedge clk);
        check("k_en_c5",    32'(mem_en),   32'd1);
        check("k_addr_c5",  32'(mem_addr), 32'h030);
        next_cycle(); next_cycle(); @(negedge clk);
        check("k_val_c7",   32'(if_valid), 32'd1);
        next_cycle(); if_req = 1'b0;

        // Reset during a data read
        do_reset();
        dm_req = 1'b1; dm_addr = 9'h060; mem_rdata = 32'hCAFE_F00D;
        next_cycle(); @(negedge clk);
        check("r_en_c1",    32'(mem_en),   32'd1);
        next_cycle(); reset = 1'b1; @(negedge clk);
        check("r_val_c2",   32'(dm_valid), 32'd0);
        next_cycle(); reset = 1'b0; dm_req = 1'b0; @(negedge clk);
        check("r_val_c3",   32'(dm_valid),  32'd0);
        check("r_data_c3",  dm_rdata,       32'd0);
        check("r_en_c3",    32'(mem_en),    32'd0);
        check("r_addr_c3",  32'(mem_addr),  32'd0);
        check("r_be_c3",    32'(mem_be),    32'd0);
        check("r_ival_c3",  32'(if_valid),  32'd0);
        next_cycle(); @(negedge clk);
        check("r_val_c4",   32'(dm_valid),  32'd0);
        dm_req = 1'b1; dm_addr = 9'h064;
        next_cycle(); @(negedge clk);
        check("r_en_c5",    32'(mem_en),    32'd1);
        check("r_addr_c5",  32'(mem_addr),  32'h064);
        next_cycle(); next_cycle(); @(negedge clk);
        check("r_val_c7",   32'(dm_valid),  32'd1);
        check("r_data_c7",  dm_rdata,       32'hCAFE_F00D);
        next_cycle(); dm_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
